rv32i_inst_fetch: RTL

//  Instruction-fetch front end: the initiator for rv32i_inst_mem (1-cycle synchronous read).

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rv32i_fetch_hold.sv | 36 +++
 rtl/rv32i_inst_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I fetch front end.
//   XLEN         : address / instruction width
//   RESET_PC_DEF : default PC loaded on reset
//   RV32_NOP     : addi x0,x0,0, driven on the decode port when nothing is valid
//   INST_BYTES   : PC increment per fetched word
package rv32i_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] RV32_NOP     = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES   = 32'd4;

    // One fetched instruction paired with its PC.
    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_word_t;

endpackage

// File: rtl/rv32i_fetch_hold.sv
// One-entry holding register for the fetch output.
// Captures the word returned by instruction memory when decode stalls, so the
// memory can be re-pointed without losing the word.
//   clk, rst  : clock, asynchronous active-low reset
//   i_capture : load i_word (ignored if i_clear is also set)
//   i_clear   : drop the held word
//   i_word    : pc/inst to capture (vld field ignored)
//   o_word    : held entry (vld = entry occupied)
module rv32i_fetch_hold
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_capture,
    input  logic        i_clear,
    input  fetch_word_t i_word,
    output fetch_word_t o_word
);

    fetch_word_t r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
        end else if (i_clear) begin
            r_word.vld <= 1'b0;
        end else if (i_capture) begin
            r_word.vld  <= 1'b1;
            r_word.pc   <= i_word.pc;
            r_word.inst <= i_word.inst;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/rv32i_inst_fetch.sv
// Instruction-fetch front end for a 1-cycle synchronous instruction memory.
// Owns the PC, issues one word address per cycle, pairs the returned word with
// its PC and presents it to decode over valid/ready. Decode back-pressure is
// absorbed by a 1-entry holding register; redirects flush everything in flight.
//   clk, rst        : clock, asynchronous active-low reset
//   o_imem_addr     : byte address to inst mem (registered PC)
//   i_imem_inst     : inst-mem data for the address sampled at the previous edge
//   i_redirect      : branch/jump taken; flush and load i_redirect_pc
//   i_redirect_pc   : redirect target (low two bits ignored)
//   o_if_valid      : o_if_inst/o_if_pc hold a valid instruction
//   i_if_ready      : decode accepts this cycle
//   o_if_inst       : instruction, NOP when not valid
//   o_if_pc         : PC of o_if_inst
//   o_fetch_cnt     : number of accepted fetches, wrapping
module rv32i_inst_fetch
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [XLEN-1:0] i_imem_inst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_if_valid,
    input  logic            i_if_ready,
    output logic [XLEN-1:0] o_if_inst,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_fetch_cnt
);

    logic [XLEN-1:0] r_pc;
    logic            r_req_vld;   // word addressed last edge is on i_imem_inst now
    logic [XLEN-1:0] r_req_pc;
    logic [31:0]     r_cnt;

    fetch_word_t     w_hold;
    fetch_word_t     w_mem_word;
    logic            w_fire;
    logic            w_issue;
    logic            w_capture;
    logic            w_clear;

    assign w_mem_word = '{vld: r_req_vld, pc: r_req_pc, inst: i_imem_inst};

    // Held word has priority: it is always older than anything in flight.
    always_comb begin
        o_if_valid = (w_hold.vld | r_req_vld) & ~i_redirect;
        o_if_pc    = w_hold.vld ? w_hold.pc : r_req_pc;
        o_if_inst  = RV32_NOP;
        if (o_if_valid) begin
            o_if_inst = w_hold.vld ? w_hold.inst : i_imem_inst;
        end
    end

    assign w_fire  = o_if_valid & i_if_ready;
    // A new address is only issued when the slot it lands in is guaranteed free.
    assign w_issue = (~o_if_valid | i_if_ready) & ~i_redirect;

    // Stalled word leaves memory next cycle (no issue), so park it.
    assign w_capture = r_req_vld & ~i_if_ready & ~w_hold.vld & ~i_redirect;
    assign w_clear   = (w_fire & w_hold.vld) | i_redirect;

    rv32i_fetch_hold u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_word    (w_mem_word),
        .o_word    (w_hold)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_req_vld <= 1'b0;
            r_req_pc  <= RESET_PC;
        end else if (i_redirect) begin
            r_pc      <= i_redirect_pc & ~XLEN'(3);
            r_req_vld <= 1'b0;
        end else if (w_issue) begin
            r_req_vld <= 1'b1;
            r_req_pc  <= r_pc;
            r_pc      <= r_pc + XLEN'(INST_BYTES);
        end else begin
            // Memory re-reads r_pc this cycle; that result is discarded.
            r_req_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_fire) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_hold.vld && r_req_vld));
        end
    end

    assign o_imem_addr = r_pc;
    assign o_fetch_cnt = r_cnt;

endmodule
